// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int MD_DATA_WIDTH = 32;

    // funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Architecturally defined results for the corner cases
    localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;  // x / 0, also the value -1
    localparam logic [31:0] MD_OVF_QUOT  = 32'h8000_0000;  // INT_MIN / -1, also INT_MIN itself
    localparam logic [31:0] MD_OVF_REM   = 32'h0000_0000;  // INT_MIN % -1

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with sign fix-up and corner-case override.
// Latency: one step per i_step strobe; o_result updates on the edge after i_fix or i_ld_res.
// Backpressure: none; fully sequenced by strobes from the owning FSM.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_load                latch op, operand magnitudes, result sign and corner-case info
//   i_step                one iteration (multiply or divide chosen by the latched op)
//   i_fix                 sign-correct the iteration result (or apply the corner case) into o_result
//   i_ld_res              with i_load: write the corner-case value straight into o_result
//   i_op, i_a, i_b        op and operands, sampled with i_load
//   o_special             combinational: i_op/i_a/i_b form a corner case with a fixed result
//   o_result              result register, holds its value between ops
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_fix,
    input  logic                  i_ld_res,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_special,
    output logic [DATA_WIDTH-1:0] o_result
);

    md_op_t                  op_in;
    logic                    in_is_div;
    logic                    sign_a, sign_b, neg_in;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic                    b_zero, div_ovf;
    logic [DATA_WIDTH-1:0]   spec_val;

    md_op_t                  op_q;
    logic                    neg_q;
    logic                    spec_q;
    logic [DATA_WIDTH-1:0]   spec_val_q;
    logic [DATA_WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic [DATA_WIDTH:0]     hi_q;       // product high half / partial remainder
    logic [DATA_WIDTH-1:0]   lo_q;       // multiplier bits / dividend bits -> quotient
    logic [DATA_WIDTH-1:0]   res_q;

    logic                    op_is_div;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     div_shift, div_diff;
    logic                    div_ge;
    logic [2*DATA_WIDTH-1:0] prod, prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, fix_val;

    assign op_in     = md_op_t'(i_op);
    assign in_is_div = i_op[2];

    // Which operands are interpreted as signed for this op
    assign sign_a = i_a[DATA_WIDTH-1] & (op_in inside {MUL, MULH, MULHSU, DIV, REM});
    assign sign_b = i_b[DATA_WIDTH-1] & (op_in inside {MUL, MULH, DIV, REM});
    assign mag_a  = sign_a ? -i_a : i_a;
    assign mag_b  = sign_b ? -i_b : i_b;
    // Remainder takes the dividend's sign; everything else the product/quotient sign
    assign neg_in = (op_in == REM) ? sign_a : (sign_a ^ sign_b);

    assign b_zero  = (i_b == '0);
    assign div_ovf = (op_in inside {DIV, REM}) && (i_a == MD_OVF_QUOT) && (i_b == MD_DIV0_QUOT);

    always_comb begin
        o_special = 1'b0;
        spec_val  = '0;
        if (in_is_div && b_zero) begin
            o_special = 1'b1;
            spec_val  = i_op[1] ? i_a : MD_DIV0_QUOT;
        end else if (div_ovf) begin
            o_special = 1'b1;
            spec_val  = i_op[1] ? MD_OVF_REM : MD_OVF_QUOT;
        end else if (!in_is_div && (i_a == '0 || b_zero)) begin
            o_special = 1'b1;
            spec_val  = '0;
        end
    end

    assign op_is_div = op_q inside {DIV, DIVU, REM, REMU};

    // Multiply: add multiplicand when the current multiplier LSB is set, then shift right
    assign mul_sum   = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: shift next dividend bit in, trial subtract; the top bit flags a borrow
    assign div_shift = {hi_q[DATA_WIDTH-1:0], lo_q[DATA_WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[DATA_WIDTH];

    assign prod     = {hi_q[DATA_WIDTH-1:0], lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_q ? -hi_q[DATA_WIDTH-1:0] : hi_q[DATA_WIDTH-1:0];

    always_comb begin
        fix_val = '0;
        case (op_q)
            MUL:                  fix_val = prod_fix[DATA_WIDTH-1:0];
            MULH, MULHSU, MULHU:  fix_val = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            DIV, DIVU:            fix_val = quo_fix;
            REM, REMU:            fix_val = rem_fix;
            default:              fix_val = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q       <= MUL;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            res_q      <= '0;
        end else if (i_load) begin
            op_q       <= op_in;
            neg_q      <= neg_in;
            spec_q     <= o_special;
            spec_val_q <= spec_val;
            hi_q       <= '0;
            if (in_is_div) begin
                lo_q   <= mag_a;
                opnd_q <= mag_b;
            end else begin
                lo_q   <= mag_b;
                opnd_q <= mag_a;
            end
            if (i_ld_res) begin
                res_q <= spec_val;
            end
        end else if (i_step) begin
            if (op_is_div) begin
                hi_q <= div_ge ? div_diff : div_shift;
                lo_q <= {lo_q[DATA_WIDTH-2:0], div_ge};
            end else begin
                hi_q <= {1'b0, mul_sum[DATA_WIDTH:1]};
                lo_q <= {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
            end
        end else if (i_fix) begin
            res_q <= spec_q ? spec_val_q : fix_val;
        end
    end

    assign o_result = res_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX ALU, with its own sequencing FSM.
// Latency: o_done in cycle DATA_WIDTH+2 after the start edge (cycle 1 for corner cases with early-out).
// Backpressure: freezes the front of the pipe via o_stall_e while busy; i_start outside IDLE is dropped.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset (aborts any op silently)
//   i_start, i_op        EX holds a valid M op (funct3 in i_op); sampled only in IDLE
//   i_a, i_b, i_rd_addr  forwarded rs1/rs2 values and destination register
//   i_flush              abort; back to IDLE at the next edge with no o_done
//   o_busy, o_stall_e    FSM not idle / stall PC, IF/ID, ID/EX
//   o_done               one-cycle result strobe; o_result and o_rd_addr valid
//   o_result, o_rd_addr  result (held between ops) and rd latched at start
// Build option MULDIV_EARLY_OUT_EN: divide by zero, DIV overflow and multiply by zero skip
// straight from IDLE to DONE; results are identical either way.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [4:0]            i_rd_addr,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_stall_e,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [4:0]            o_rd_addr
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       rd_q;
    logic             load, step, fix, ld_res;
    logic             special;
    logic             accept;

    assign accept = i_start & ~i_flush;

`ifndef MULDIV_EARLY_OUT_EN
    logic special_unused;
    assign special_unused = special;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                rd_q <= i_rd_addr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        ld_res    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_nxt = '0;
`ifdef MULDIV_EARLY_OUT_EN
                    if (special) begin
                        ld_res    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = CALC;
                    end
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                step    = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = FIX;
                end
            end
            FIX: begin
                fix       = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Flush overrides everything, including a same-cycle start
        if (i_flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            step      = 1'b0;
            fix       = 1'b0;
        end
    end

    muldiv_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (load),
        .i_step    (step),
        .i_fix     (fix),
        .i_ld_res  (ld_res),
        .i_op      (i_op),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_special (special),
        .o_result  (o_result)
    );

    assign o_busy    = (state != IDLE);
    // Low in DONE so EX/MEM advances and captures the result that cycle
    assign o_stall_e = ((state == IDLE) & accept) | (state == CALC) | (state == FIX);
    // A flush landing on the DONE cycle suppresses the write-back strobe
    assign o_done    = (state == DONE) & ~i_flush;
    assign o_rd_addr = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_op      (op),
        .i_a       (a),
        .i_b       (b),
        .i_rd_addr (rd),
        .i_flush   (flush),
        .o_busy    (busy),
        .o_stall_e (stall),
        .o_done    (done),
        .o_result  (result),
        .o_rd_addr (rd_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M results from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, ps;
        longint unsigned ux, uy, pu;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        ps  = 0;
        pu  = 0;
        case (o)
            3'd0: begin ps = sx * sy;           return ps[31:0];  end
            3'd1: begin ps = sx * sy;           return ps[63:32]; end
            3'd2: begin ps = sx * longint'(uy); return ps[63:32]; end
            3'd3: begin pu = ux * uy;           return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                ps = sx / sy; return ps[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf)    return 32'h0;
                ps = sx % sy; return ps[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic sp;
        sp = (o >= 3'd4 && y == 0) ||
             ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ||
             (o < 3'd4 && (x == 0 || y == 0));
`ifdef MULDIV_EARLY_OUT_EN
        if (sp) return 1;
`else
        if (sp) return 34;
`endif
        return 34;
    endfunction

    // Caller is positioned in the low phase of an IDLE cycle (cycle 0)
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] r);
        int          cyc;
        int          stall_low;
        logic [31:0] exp_res;
        exp_res = ref_result(o, x, y);
        op = o; a = x; b = y; rd = r; start = 1'b1;
        #1;
        chk({tag, " stall_c0"}, 32'(stall), 32'd1);
        @(negedge clk);
        // Scramble inputs: the unit must work from what it latched
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
        cyc = 1;
        stall_low = 0;
        while (!done && cyc < 60) begin
            if (!stall) stall_low++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(exp_latency(o, x, y)));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " rd"}, 32'(rd_out), 32'(r));
        chk({tag, " stall_done"}, 32'(stall), 32'd0);
        chk({tag, " stall_gaps"}, 32'(stall_low), 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          cyc;
        int          nd;
        int          first;
        logic [31:0] res_seen;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd = '0;
        repeat (2) @(negedge clk);
        chk("rst busy",   32'(busy),   32'd0);
        chk("rst stall",  32'(stall),  32'd0);
        chk("rst done",   32'(done),   32'd0);
        chk("rst result", result,      32'd0);
        chk("rst rd",     32'(rd_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("mul_7x-3",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3);
        run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5);
        run_op("mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF,  32'd2,         5'd6);
        run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         5'd7);
        run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         5'd8);
        run_op("div_-7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9);
        run_op("rem_-7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10);
        run_op("div_5_0",      3'd4, 32'd5,          32'd0,         5'd11);
        run_op("remu_5_0",     3'd7, 32'd5,          32'd0,         5'd12);
        run_op("rem_-5_0",     3'd6, 32'hFFFF_FFFB,  32'd0,         5'd13);
        run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14);
        run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15);
        run_op("mul_zero",     3'd0, 32'd0,          32'h1234_5678, 5'd16);

        // Randomized ops, biased toward corner operands
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'd0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), ra, rb, 5'($urandom));
        end

        // Flush in cycle 10, then restart immediately
        op = 3'd0; a = 32'd9; b = 32'd9; rd = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nd = 0;
        while (cyc < 10) begin
            if (done) nd++;
            @(negedge clk);
            cyc++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush idle", 32'(busy), 32'd0);
        chk("flush no_done", 32'(nd + int'(done)), 32'd0);
        run_op("flush_restart", 3'd5, 32'd1000, 32'd10, 5'd2);

        // Flush and start together: flush wins
        op = 3'd1; a = 32'd3; b = 32'd3; rd = 5'd3; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_start stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start idle", 32'(busy), 32'd0);

        // Start pulsed mid-CALC is ignored
        op = 3'd0; a = 32'd3; b = 32'd5; rd = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nd = 0; first = 0; res_seen = '0;
        while (cyc < 80) begin
            if (done) begin
                nd++;
                if (nd == 1) begin
                    first = cyc;
                    res_seen = result;
                end
            end
            start = (cyc == 5);
            if (cyc == 5) begin
                op = 3'd5; a = 32'd9; b = 32'd3;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("ignore ndone", 32'(nd), 32'd1);
        chk("ignore latency", 32'(first), 32'd34);
        chk("ignore result", res_seen, 32'd15);

        // Reset in cycle 5 aborts silently
        op = 3'd4; a = 32'd77; b = 32'd7; rd = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst busy",   32'(busy),   32'd0);
        chk("midrst stall",  32'(stall),  32'd0);
        chk("midrst done",   32'(done),   32'd0);
        chk("midrst result", result,      32'd0);
        chk("midrst rd",     32'(rd_out), 32'd0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst no_done", 32'(nd), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
